// File: rtl/feistel_pkg.sv
// Shared types and helpers for the iterative Feistel cipher: FSM states,
// width-generic rotates and the round F-function (operands up to MAXW bits).
package feistel_pkg;

    localparam int unsigned MAXW = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [MAXW-1:0] wmask(input int unsigned w);
        return {MAXW{1'b1}} >> (MAXW - w);
    endfunction

    // Rotate left the low w bits of x by n (mod w); bits above w read as 0.
    function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] x,
                                             input int unsigned n,
                                             input int unsigned w);
        logic [MAXW-1:0] m;
        logic [MAXW-1:0] xm;
        logic [MAXW-1:0] res;
        int unsigned     s;
        m  = wmask(w);
        xm = x & m;
        s  = n % w;
        if (s == 0) res = xm;
        else        res = ((xm << s) | (xm >> (w - s))) & m;
        return res;
    endfunction

    function automatic logic [MAXW-1:0] rotr(input logic [MAXW-1:0] x,
                                             input int unsigned n,
                                             input int unsigned w);
        return rotl(x, w - (n % w), w);
    endfunction

    // F(x,k) = rotl(x^k, rot1) + rotl(x, rot2), modulo 2^h.
    function automatic logic [MAXW-1:0] feistel_f(input logic [MAXW-1:0] x,
                                                  input logic [MAXW-1:0] k,
                                                  input int unsigned rot1,
                                                  input int unsigned rot2,
                                                  input int unsigned h);
        return (rotl(x ^ k, rot1, h) + rotl(x, rot2, h)) & wmask(h);
    endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel round: (L, R, K) -> (R, L ^ F(R, K)).
module feistel_round
    import feistel_pkg::*;
#(
    parameter int unsigned H    = 64,
    parameter int unsigned ROT1 = 3,
    parameter int unsigned ROT2 = 8
) (
    input  logic [H-1:0] l,
    input  logic [H-1:0] r,
    input  logic [H-1:0] k,
    output logic [H-1:0] l_next_c,
    output logic [H-1:0] r_next_c
);

    assign l_next_c = r;
    assign r_next_c = l ^ H'(feistel_f(MAXW'(r), MAXW'(k), ROT1, ROT2, H));

endmodule

// File: rtl/feistel_cipher_core.sv
// Iterative Feistel block cipher, one round per clock, encrypt or decrypt per
// block, valid/ready on both sides. Key material is zeroized after hand-off.
module feistel_cipher_core
    import feistel_pkg::*;
#(
    parameter int unsigned W      = 128,
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned ROT1   = 3,
    parameter int unsigned ROT2   = 8,
    parameter int unsigned KROT   = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [W-1:0] data_in,
    input  logic [W-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic         busy
);

    localparam int unsigned H     = W / 2;
    localparam int unsigned CW    = $clog2(ROUNDS) + 1;
    localparam int unsigned DKROT = ((ROUNDS - 1) * KROT) % W;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t        state_q, state_d;
    logic [H-1:0]  l_q, l_d, r_q, r_d;
    logic [W-1:0]  kr_q, kr_d;
    logic [CW-1:0] rnd_q, rnd_d;
    logic          dec_q, dec_d;
    logic          in_ready_d, out_valid_d, busy_d;
    logic [W-1:0]  data_out_d;

    logic [CW-1:0] reff_c;
    logic [H-1:0]  rk_c, l_rnd_c, r_rnd_c;
    logic [W-1:0]  kr_fwd_c, kr_bwd_c, key_dec_c;

    // Decrypt walks the same key schedule backwards, starting at the last round key.
    assign reff_c    = dec_q ? (LAST - rnd_q) : rnd_q;
    assign rk_c      = kr_q[H-1:0] ^ H'(reff_c);
    assign kr_fwd_c  = W'(rotl(MAXW'(kr_q), KROT, W));
    assign kr_bwd_c  = W'(rotr(MAXW'(kr_q), KROT, W));
    assign key_dec_c = W'(rotl(MAXW'(key), DKROT, W));

    feistel_round #(
        .H    (H),
        .ROT1 (ROT1),
        .ROT2 (ROT2)
    ) u_round (
        .l        (l_q),
        .r        (r_q),
        .k        (rk_c),
        .l_next_c (l_rnd_c),
        .r_next_c (r_rnd_c)
    );

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        kr_d    = kr_q;
        rnd_d   = rnd_q;
        dec_d   = dec_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    l_d     = data_in[W-1:H];
                    r_d     = data_in[H-1:0];
                    kr_d    = decrypt ? key_dec_c : key;
                    rnd_d   = '0;
                    dec_d   = decrypt;
                end
            end
            RUN: begin
                l_d   = l_rnd_c;
                r_d   = r_rnd_c;
                kr_d  = dec_q ? kr_bwd_c : kr_fwd_c;
                rnd_d = rnd_q + CW'(1);
                if (rnd_q == LAST) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    l_d     = '0;
                    r_d     = '0;
                    kr_d    = '0;
                    rnd_d   = '0;
                    dec_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered copies of what the next state presents.
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
        data_out_d  = out_valid_d ? {r_d, l_d} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            l_q       <= '0;
            r_q       <= '0;
            kr_q      <= '0;
            rnd_q     <= '0;
            dec_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            data_out  <= '0;
        end else begin
            state_q   <= state_d;
            l_q       <= l_d;
            r_q       <= r_d;
            kr_q      <= kr_d;
            rnd_q     <= rnd_d;
            dec_q     <= dec_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            data_out  <= data_out_d;
        end
    end

endmodule
